// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared program/data memory.
// CPU port C and debug port D, round-robin with burst limit and debug lock.
module mem_port_arbiter #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MAX_BURST            = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            c_req_i,
  input  logic                            c_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] c_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       c_wdata_i,
  output logic                            c_gnt_o,
  output logic [REGISTER_WIDTH-1:0]       c_rdata_o,
  input  logic                            d_req_i,
  input  logic                            d_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] d_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       d_wdata_i,
  input  logic                            d_lock_i,
  output logic                            d_gnt_o,
  output logic [REGISTER_WIDTH-1:0]       d_rdata_o,
  output logic                            read_en_mem_o,
  output logic                            write_en_mem_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] addr_mem_o,
  output logic [REGISTER_WIDTH-1:0]       write_data_mem_o,
  input  logic [REGISTER_WIDTH-1:0]       read_data_mem_i,
  output logic                            busy_o
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LP_SAT  = CW'(MAX_BURST);
  localparam logic [CW-1:0] LP_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    stIDLE,
    stOWN_C,
    stOWN_D
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_owner;
  logic [CW-1:0]   r_burst_cnt;
  logic            r_c_gnt;
  logic            r_d_gnt;
  logic            r_busy;

  logic            w_expired;
  logic            w_c_act;
  logic            w_d_act;

  // Lock keeps the saturated counter, so expiry uses >= not ==.
  assign w_expired = (r_burst_cnt >= LP_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      stIDLE: begin
        if (c_req_i && d_req_i)
          w_next = r_last_owner ? stOWN_C : stOWN_D;
        else if (c_req_i)
          w_next = stOWN_C;
        else if (d_req_i)
          w_next = stOWN_D;
      end
      stOWN_C: begin
        if (!c_req_i)
          w_next = d_req_i ? stOWN_D : stIDLE;
        else if (d_req_i && w_expired)
          w_next = stOWN_D;
      end
      stOWN_D: begin
        if (!d_req_i)
          w_next = c_req_i ? stOWN_C : stIDLE;
        else if (c_req_i && !d_lock_i && w_expired)
          w_next = stOWN_C;
      end
      default: w_next = stIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= stIDLE;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
      r_c_gnt      <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_c_gnt <= (w_next == stOWN_C);
      r_d_gnt <= (w_next == stOWN_D);
      r_busy  <= (w_next != stIDLE);
      if (w_next != r_state) begin
        r_burst_cnt <= '0;
        if (w_next == stOWN_C)
          r_last_owner <= 1'b0;
        else if (w_next == stOWN_D)
          r_last_owner <= 1'b1;
      end else if (r_state == stIDLE) begin
        r_burst_cnt <= '0;
      end else if (r_burst_cnt != LP_SAT) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

  // Owner drives the memory only while its request is still up.
  assign w_c_act = r_c_gnt & c_req_i;
  assign w_d_act = r_d_gnt & d_req_i;

  assign c_gnt_o = r_c_gnt;
  assign d_gnt_o = r_d_gnt;
  assign busy_o  = r_busy;

  assign read_en_mem_o  = (w_c_act & ~c_we_i) | (w_d_act & ~d_we_i);
  assign write_en_mem_o = (w_c_act & c_we_i) | (w_d_act & d_we_i);

  assign addr_mem_o =
    w_c_act ? c_addr_i :
    w_d_act ? d_addr_i : '0;

  assign write_data_mem_o =
    (w_c_act & c_we_i) ? c_wdata_i :
    (w_d_act & d_we_i) ? d_wdata_i : '0;

  assign c_rdata_o = (w_c_act & ~c_we_i) ? read_data_mem_i : '0;
  assign d_rdata_o = (w_d_act & ~d_we_i) ? read_data_mem_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model.
// Inputs change #1 after posedge; outputs sampled #2 after posedge.
module tb_mem_port_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       c_req_i = 1'b0, c_we_i = 1'b0;
  logic [3:0] c_addr_i = '0, c_wdata_i = '0;
  logic       c_gnt_o;
  logic [3:0] c_rdata_o;
  logic       d_req_i = 1'b0, d_we_i = 1'b0, d_lock_i = 1'b0;
  logic [3:0] d_addr_i = '0, d_wdata_i = '0;
  logic       d_gnt_o;
  logic [3:0] d_rdata_o;
  logic       read_en_mem_o, write_en_mem_o;
  logic [3:0] addr_mem_o, write_data_mem_o;
  logic [3:0] read_data_mem_i;
  logic       busy_o;

  logic [3:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;
  int own_c;
  int own_d;
  bit saw_d;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .REGISTER_WIDTH(4),
    .MEMORY_ADDRESS_WIDTH(4),
    .MAX_BURST(8)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .c_req_i(c_req_i),
    .c_we_i(c_we_i),
    .c_addr_i(c_addr_i),
    .c_wdata_i(c_wdata_i),
    .c_gnt_o(c_gnt_o),
    .c_rdata_o(c_rdata_o),
    .d_req_i(d_req_i),
    .d_we_i(d_we_i),
    .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i),
    .d_lock_i(d_lock_i),
    .d_gnt_o(d_gnt_o),
    .d_rdata_o(d_rdata_o),
    .read_en_mem_o(read_en_mem_o),
    .write_en_mem_o(write_en_mem_o),
    .addr_mem_o(addr_mem_o),
    .write_data_mem_o(write_data_mem_o),
    .read_data_mem_i(read_data_mem_i),
    .busy_o(busy_o)
  );

  // Memory preloads mem[3]=A on reset, combinational read.
  assign read_data_mem_i = mem[addr_mem_o];
  always @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
      mem[3] <= 4'hA;
    end else if (write_en_mem_o) begin
      mem[addr_mem_o] <= write_data_mem_o;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // 1: reset, then single CPU read
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    settle();
    chk("rst_cgnt", 32'(c_gnt_o), 0);
    chk("rst_dgnt", 32'(d_gnt_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ren", 32'(read_en_mem_o), 0);
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 4'd3;
    settle();
    chk("t1_nogntyet", 32'(c_gnt_o), 0);
    tick();
    settle();
    chk("t1_cgnt", 32'(c_gnt_o), 1);
    chk("t1_ren", 32'(read_en_mem_o), 1);
    chk("t1_wen", 32'(write_en_mem_o), 0);
    chk("t1_addr", 32'(addr_mem_o), 3);
    chk("t1_rdata", 32'(c_rdata_o), 32'hA);
    chk("t1_dgnt", 32'(d_gnt_o), 0);
    chk("t1_busy", 32'(busy_o), 1);
    c_req_i = 1'b0;
    settle();
    chk("t1_rel_ren", 32'(read_en_mem_o), 0);
    chk("t1_rel_rdata", 32'(c_rdata_o), 0);
    tick();
    settle();
    chk("t1_idle", 32'(busy_o), 0);

    // 2: simultaneous request after reset -> C first, then D, no bubble
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    c_req_i = 1'b1; d_req_i = 1'b1;
    tick();
    settle();
    chk("t2_cfirst", 32'(c_gnt_o), 1);
    chk("t2_dwait", 32'(d_gnt_o), 0);
    chk("t2_drdata0", 32'(d_rdata_o), 0);
    c_req_i = 1'b0;
    tick();
    settle();
    chk("t2_dnext", 32'(d_gnt_o), 1);
    chk("t2_cdone", 32'(c_gnt_o), 0);
    chk("t2_nobubble", 32'(busy_o), 1);
    d_req_i = 1'b0;
    tick();

    // 3: burst limit, C held, D arrives during 2nd owned cycle
    c_req_i = 1'b1;
    own_c = 0;
    saw_d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      if (d_gnt_o) begin
        saw_d = 1'b1;
        break;
      end
      if (c_gnt_o) own_c++;
      if (own_c == 2) d_req_i = 1'b1;
    end
    chk("t3_cburst", 32'(own_c), 8);
    chk("t3_dgot", 32'(saw_d), 1);
    chk("t3_cout", 32'(c_gnt_o), 0);
    d_req_i = 1'b0;
    tick();
    settle();
    chk("t3_cback", 32'(c_gnt_o), 1);
    c_req_i = 1'b0;
    tick();

    // 4: locked debug session ignores CPU pressure
    d_req_i = 1'b1; d_lock_i = 1'b1;
    tick();
    settle();
    chk("t4_dgnt", 32'(d_gnt_o), 1);
    c_req_i = 1'b1;
    own_d = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      settle();
      if (d_gnt_o && !c_gnt_o) own_d++;
    end
    chk("t4_locked", 32'(own_d), 20);
    d_lock_i = 1'b0;
    tick();
    settle();
    chk("t4_unlock_c", 32'(c_gnt_o), 1);
    chk("t4_unlock_d", 32'(d_gnt_o), 0);
    c_req_i = 1'b0; d_req_i = 1'b0;
    tick();
    tick();

    // 5: debug write, CPU readback
    d_req_i = 1'b1; d_we_i = 1'b1;
    d_addr_i = 4'd5; d_wdata_i = 4'h7;
    tick();
    settle();
    chk("t5_dgnt", 32'(d_gnt_o), 1);
    chk("t5_wen", 32'(write_en_mem_o), 1);
    chk("t5_ren", 32'(read_en_mem_o), 0);
    chk("t5_addr", 32'(addr_mem_o), 5);
    chk("t5_wdata", 32'(write_data_mem_o), 7);
    chk("t5_drdata", 32'(d_rdata_o), 0);
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0;
    c_req_i = 1'b1; c_we_i = 1'b0; c_addr_i = 4'd5;
    tick();
    settle();
    chk("t5_cgnt", 32'(c_gnt_o), 1);
    chk("t5_readback", 32'(c_rdata_o), 7);

    // 6: reset mid C burst; CPU was last owner, tie still goes to C
    for (int i = 0; i < 4; i++) tick();
    d_req_i = 1'b1;
    reset_i = 1'b1;
    tick();
    settle();
    chk("t6_cgnt", 32'(c_gnt_o), 0);
    chk("t6_dgnt", 32'(d_gnt_o), 0);
    chk("t6_busy", 32'(busy_o), 0);
    chk("t6_ren", 32'(read_en_mem_o), 0);
    chk("t6_wen", 32'(write_en_mem_o), 0);
    reset_i = 1'b0;
    tick();
    settle();
    chk("t6_tie_c", 32'(c_gnt_o), 1);
    chk("t6_tie_d", 32'(d_gnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
